// File: rtl/bcd_entry_to_bin.sv
// rtl/bcd_entry_to_bin.sv - keypad-style BCD digit entry converted to a 9-bit binary value
module bcd_entry_to_bin #(
  parameter int MAX_DIGITS = 3,
  parameter int MAX_VAL    = 511
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       clear,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  output logic       digit_ready,
  input  logic       enter,
  output logic [8:0] bin_out,
  output logic       bin_valid,
  input  logic       bin_ready,
  output logic       err,
  output logic [1:0] digit_count
);

  localparam logic [1:0] MAXD = 2'(MAX_DIGITS);
  localparam logic [9:0] MAXV = 10'(MAX_VAL);

  typedef enum logic [1:0] {COLLECT, MAC, HOLD, ERROR} state_t;

  state_t     state, state_nx;
  logic [9:0] acc, acc_nx;
  logic [3:0] dreg, dreg_nx;
  logic [1:0] count_nx;
  logic [8:0] bin_nx;
  logic       bvalid_nx, err_nx;
  logic       take;

  assign digit_ready = (state == COLLECT) && (digit_count < MAXD);
  assign take        = digit_valid && digit_ready && !clear;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= COLLECT;
    else         state <= state_nx;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      acc         <= '0;
      dreg        <= '0;
      digit_count <= '0;
      bin_out     <= '0;
      bin_valid   <= 1'b0;
      err         <= 1'b0;
    end else begin
      acc         <= acc_nx;
      dreg        <= dreg_nx;
      digit_count <= count_nx;
      bin_out     <= bin_nx;
      bin_valid   <= bvalid_nx;
      err         <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    dreg_nx   = dreg;
    count_nx  = digit_count;
    bin_nx    = bin_out;
    bvalid_nx = bin_valid;
    err_nx    = err;
    if (clear) begin
      state_nx  = COLLECT;
      acc_nx    = '0;
      dreg_nx   = '0;
      count_nx  = '0;
      bin_nx    = '0;
      bvalid_nx = 1'b0;
      err_nx    = 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          // An accepted digit takes priority; a simultaneous enter is dropped.
          if (take) begin
            if (digit_in > 4'd9) begin
              state_nx = ERROR;
              err_nx   = 1'b1;
            end else begin
              dreg_nx  = digit_in;
              state_nx = MAC;
            end
          end else if (enter && (digit_count != 2'd0)) begin
            if (acc <= MAXV) begin
              bin_nx    = acc[8:0];
              bvalid_nx = 1'b1;
              state_nx  = HOLD;
            end else begin
              err_nx   = 1'b1;
              state_nx = ERROR;
            end
          end
        end
        MAC: begin
          acc_nx   = (acc * 10'd10) + {6'd0, dreg};
          count_nx = digit_count + 2'd1;
          state_nx = COLLECT;
        end
        HOLD: begin
          if (bin_ready) begin
            bvalid_nx = 1'b0;
            acc_nx    = '0;
            count_nx  = '0;
            state_nx  = COLLECT;
          end
        end
        default: begin
          err_nx = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// tb/tb_bcd_entry_to_bin.sv - directed-vector bench for bcd_entry_to_bin
module tb_bcd_entry_to_bin;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       digit_ready;
  logic       enter = 1'b0;
  logic [8:0] bin_out;
  logic       bin_valid;
  logic       bin_ready = 1'b0;
  logic       err;
  logic [1:0] digit_count;

  int errors = 0;
  int checks = 0;

  bcd_entry_to_bin dut (
    .Clock(Clock), .Resetn(Resetn), .clear(clear),
    .digit_in(digit_in), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .enter(enter), .bin_out(bin_out), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .err(err), .digit_count(digit_count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    step();
  endtask

  task automatic press_enter();
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic accept_out();
    bin_ready = 1'b1;
    step();
    bin_ready = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_ready", digit_ready, 1);
    check("rst_valid", bin_valid, 0);
    check("rst_err", err, 0);
    check("rst_count", digit_count, 0);
    check("rst_bin", bin_out, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    step();

    // 255 held for five cycles of back-pressure
    send_digit(4'd2); send_digit(4'd5); send_digit(4'd5);
    check("255_count", digit_count, 3);
    press_enter();
    check("255_valid", bin_valid, 1);
    check("255_bin", bin_out, 255);
    for (int i = 0; i < 5; i++) step();
    check("255_hold_valid", bin_valid, 1);
    check("255_hold_bin", bin_out, 255);
    check("255_hold_ready", digit_ready, 0);
    accept_out();
    check("255_done_valid", bin_valid, 0);
    check("255_done_count", digit_count, 0);
    check("255_done_bin", bin_out, 255);

    // 512 overflows, clear, then a single digit 7
    send_digit(4'd5); send_digit(4'd1); send_digit(4'd2);
    press_enter();
    check("512_err", err, 1);
    check("512_ready", digit_ready, 0);
    check("512_valid", bin_valid, 0);
    step();
    check("512_valid_later", bin_valid, 0);
    pulse_clear();
    check("clr_err", err, 0);
    check("clr_ready", digit_ready, 1);
    check("clr_bin", bin_out, 0);
    send_digit(4'd7);
    press_enter();
    check("7_bin", bin_out, 7);
    check("7_valid", bin_valid, 1);
    accept_out();

    // 511 is the largest legal value
    send_digit(4'd5); send_digit(4'd1); send_digit(4'd1);
    press_enter();
    check("511_err", err, 0);
    check("511_bin", bin_out, 511);
    accept_out();

    // non-BCD digit latches error, later digits ignored until clear
    digit_in = 4'hA; digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    check("nbcd_err", err, 1);
    send_digit(4'd3);
    check("nbcd_count", digit_count, 0);
    check("nbcd_err_sticky", err, 1);
    pulse_clear();
    check("nbcd_clr", err, 0);

    // enter with no digits, then a fourth digit that must be refused
    press_enter();
    step();
    check("e0_valid", bin_valid, 0);
    check("e0_count", digit_count, 0);
    send_digit(4'd1); send_digit(4'd2); send_digit(4'd3);
    check("123_ready", digit_ready, 0);
    send_digit(4'd7);
    check("123_count", digit_count, 3);
    check("123_noerr", err, 0);
    press_enter();
    check("123_bin", bin_out, 123);
    accept_out();

    // digit and enter on the same edge: digit wins
    send_digit(4'd0); send_digit(4'd7);
    digit_in = 4'd3; digit_valid = 1'b1; enter = 1'b1;
    step();
    digit_valid = 1'b0; enter = 1'b0;
    check("073_drop", bin_valid, 0);
    step();
    check("073_count", digit_count, 3);
    check("073_still", bin_valid, 0);
    press_enter();
    check("073_bin", bin_out, 73);
    check("073_valid", bin_valid, 1);

    // clear while holding a result
    pulse_clear();
    check("hclr_valid", bin_valid, 0);
    check("hclr_bin", bin_out, 0);

    // async reset while in MAC
    send_digit(4'd4);
    digit_in = 4'd9; digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    #1 Resetn = 1'b0;
    #1;
    check("ar_count", digit_count, 0);
    check("ar_ready", digit_ready, 1);
    check("ar_valid", bin_valid, 0);
    check("ar_err", err, 0);
    #1 Resetn = 1'b1;
    step();
    check("ar_mac_lost", digit_count, 0);
    digit_in = 4'd6; digit_valid = 1'b1;
    step();
    digit_valid = 1'b0;
    step();
    check("ar_first", digit_count, 1);
    press_enter();
    check("ar_bin", bin_out, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
